// File: rtl/delay_tap_pkg.sv
// Shared types and elaboration helpers for the delay_tap_ctrl slice.
// Tap width and default-tap clamping live here so every file agrees.
package delay_tap_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STEP,
    SETTLE
  } state_t;

  function automatic int tap_w(int taps);
    return (taps > 1) ? $clog2(taps) : 1;
  endfunction

  function automatic int clamp_default(
    logic [127:0] mode,
    int           value,
    int           taps
  );
    if (mode == "SCLK_ZEROHOLD") return 0;
    if (value < 0) return 0;
    if (value >= taps) return taps - 1;
    return value;
  endfunction

endpackage

// File: rtl/delay_tap_line.sv
// One delay channel: TAPS-1 deep shift register plus tap select.
// Tap 0 is a combinational bypass; tap n picks the sample n cycles old.
module delay_tap_line
  import delay_tap_pkg::*;
#(
  parameter int TAPS = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    a,
  input  logic [tap_w(TAPS)-1:0]  tap,
  output logic                    z
);

  logic [TAPS-2:0] hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= '0;
    end else begin
      hist[0] <= a;
      for (int k = 1; k < TAPS - 1; k++) begin
        hist[k] <= hist[k-1];
      end
    end
  end

  always_comb begin
    z = a;
    if (tap != '0) z = hist[tap - 1'b1];
  end

endmodule

// File: rtl/delay_tap_ctrl.sv
// Multi-channel programmable input delay with MOVE/DIRECTION stepping.
// Define DELAY_TAPOUT_EN to expose all tap counters on TAP_OUT.
module delay_tap_ctrl
  import delay_tap_pkg::*;
#(
  parameter int           NCH        = 4,
  parameter int           TAPS       = 32,
  parameter logic [127:0] DEL_MODE   = "USER_DEFINED",
  parameter int           DEL_VALUE  = 0,
  parameter int           SETTLE_CYC = 2
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic [NCH-1:0]                       A,
  output logic [NCH-1:0]                       Z,
  input  logic                                 LOADN,
  input  logic                                 MOVE,
  input  logic                                 DIRECTION,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] CH_SEL,
  output logic                                 BUSY,
  output logic                                 CFLAG
`ifdef DELAY_TAPOUT_EN
  ,
  output logic [NCH*tap_w(TAPS)-1:0]           TAP_OUT
`endif
);

  localparam int TW    = tap_w(TAPS);
  localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [TW-1:0] DEF_TAP =
    TW'(clamp_default(DEL_MODE, DEL_VALUE, TAPS));
  localparam logic [TW-1:0] TOP_TAP = TW'(TAPS - 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE_CYC - 1);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             move_q;
  logic             move_edge;
  logic             dir_q;
  logic [CW-1:0]    sel_q;
  logic             sel_ok;
  logic [TW-1:0]    tap [NCH];

  assign move_edge = MOVE & ~move_q;
  assign sel_ok    = 32'(sel_q) < NCH;
  assign BUSY      = (state == SETTLE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      cnt    <= '0;
      move_q <= 1'b0;
      sel_q  <= '0;
      dir_q  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      move_q <= MOVE;
      if (state == IDLE && move_edge) begin
        sel_q <= CH_SEL;
        dir_q <= DIRECTION;
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (move_edge) state_n = STEP;
      end
      STEP: begin
        state_n = SETTLE;
        cnt_n   = '0;
      end
      SETTLE: begin
        if (cnt == LAST) state_n = IDLE;
        else cnt_n = cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
    // A load aborts any step in flight
    if (!LOADN) begin
      state_n = IDLE;
      cnt_n   = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NCH; i++) tap[i] <= DEF_TAP;
      CFLAG <= 1'b0;
    end else if (!LOADN) begin
      for (int i = 0; i < NCH; i++) tap[i] <= DEF_TAP;
      CFLAG <= 1'b0;
    end else if (state == STEP && sel_ok) begin
      if (!dir_q) begin
        if (tap[sel_q] == TOP_TAP) CFLAG <= 1'b1;
        else tap[sel_q] <= tap[sel_q] + 1'b1;
      end else begin
        if (tap[sel_q] == '0) CFLAG <= 1'b1;
        else tap[sel_q] <= tap[sel_q] - 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    delay_tap_line #(
      .TAPS(TAPS)
    ) u_line (
      .clk(CLK),
      .rst(RST),
      .a  (A[i]),
      .tap(tap[i]),
      .z  (Z[i])
    );
`ifdef DELAY_TAPOUT_EN
    assign TAP_OUT[i*TW +: TW] = tap[i];
`endif
  end

endmodule

// File: tb/tb_delay_tap_ctrl.sv
// Bench for delay_tap_ctrl: directed plan plus random traffic vs a model.
// Model keeps a queue of past A samples and per-channel tap integers.
module tb_delay_tap_ctrl;

  localparam int NCH  = 4;
  localparam int TAPS = 32;
  localparam int DEF  = 3;
  localparam int SET  = 2;

  logic           clk = 1'b0;
  logic           RST = 1'b1;
  logic [NCH-1:0] A = '0;
  logic [NCH-1:0] Z;
  logic           LOADN = 1'b1;
  logic           MOVE = 1'b0;
  logic           DIRECTION = 1'b0;
  logic [1:0]     CH_SEL = '0;
  logic           BUSY;
  logic           CFLAG;
`ifdef DELAY_TAPOUT_EN
  logic [NCH*5-1:0] TAP_OUT;
`endif

  int checks = 0;
  int failures = 0;

  int             m_tap [NCH];
  bit             m_cflag;
  int             busy_left;
  bit             pend;
  int             p_sel;
  bit             p_dir;
  bit             move_prev;
  logic [NCH-1:0] past [$];

  always #5 clk = ~clk;

  delay_tap_ctrl #(
    .NCH       (NCH),
    .TAPS      (TAPS),
    .DEL_MODE  ("USER_DEFINED"),
    .DEL_VALUE (DEF),
    .SETTLE_CYC(SET)
  ) dut (
    .CLK      (clk),
    .RST      (RST),
    .A        (A),
    .Z        (Z),
    .LOADN    (LOADN),
    .MOVE     (MOVE),
    .DIRECTION(DIRECTION),
    .CH_SEL   (CH_SEL),
    .BUSY     (BUSY),
    .CFLAG    (CFLAG)
`ifdef DELAY_TAPOUT_EN
    ,
    .TAP_OUT  (TAP_OUT)
`endif
  );

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_tap[i]) m_tap[i] = DEF;
    m_cflag   = 1'b0;
    busy_left = 0;
    pend      = 1'b0;
    move_prev = 1'b0;
    past.delete();
  endtask

  task automatic model_step();
    bit e;
    if (RST) return;
    e = MOVE && !move_prev;
    move_prev = MOVE;
    past.push_front(A);
    if (past.size() > TAPS) void'(past.pop_back());
    if (!LOADN) begin
      foreach (m_tap[i]) m_tap[i] = DEF;
      m_cflag   = 1'b0;
      pend      = 1'b0;
      busy_left = 0;
    end else if (pend) begin
      pend      = 1'b0;
      busy_left = SET;
      if (p_sel < NCH) begin
        if (!p_dir) begin
          if (m_tap[p_sel] == TAPS - 1) m_cflag = 1'b1;
          else m_tap[p_sel]++;
        end else begin
          if (m_tap[p_sel] == 0) m_cflag = 1'b1;
          else m_tap[p_sel]--;
        end
      end
    end else if (busy_left > 0) begin
      busy_left--;
    end else if (e) begin
      pend  = 1'b1;
      p_sel = int'(CH_SEL);
      p_dir = DIRECTION;
    end
  endtask

  function automatic logic [NCH-1:0] model_z();
    logic [NCH-1:0] r;
    logic [NCH-1:0] s;
    int t;
    for (int i = 0; i < NCH; i++) begin
      t = m_tap[i];
      if (t == 0) begin
        r[i] = A[i];
      end else if (t <= past.size()) begin
        s = past[t-1];
        r[i] = s[i];
      end else begin
        r[i] = 1'b0;
      end
    end
    return r;
  endfunction

  task automatic check_model();
    chk("model_z", 32'(Z), 32'(model_z()));
    chk("model_busy", 32'(BUSY), 32'(busy_left > 0));
    chk("model_cflag", 32'(CFLAG), 32'(m_cflag));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic do_move(int ch, bit dir);
    CH_SEL    = 2'(ch);
    DIRECTION = dir;
    MOVE      = 1'b1;
    tick();
    MOVE = 1'b0;
    repeat (4) tick();
  endtask

  task automatic delay_probe(int ch, int d);
    logic [NCH-1:0] v;
    A = '0;
    repeat (10) tick();
    v = '0;
    v[ch] = 1'b1;
    A = v;
    #1;
    for (int k = 0; k <= d; k++) begin
      if (k > 0) tick();
      chk($sformatf("delay_ch%0d_k%0d", ch, k),
          32'(Z[ch]), 32'(k == d));
    end
  endtask

  initial begin
    model_reset();
    #2;
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_cflag", 32'(CFLAG), 32'd0);
    chk("rst_z", 32'(Z), 32'd0);
    repeat (2) @(negedge clk);
    RST = 1'b0;

    // default tap 3 on channel 0
    tick();
    A = 4'b0001;
    tick();
    chk("ch0_edge1", 32'(Z[0]), 32'd0);
    tick();
    chk("ch0_edge2", 32'(Z[0]), 32'd0);
    tick();
    chk("ch0_edge3", 32'(Z[0]), 32'd1);
    chk("ch0_busy", 32'(BUSY), 32'd0);
    chk("ch0_cflag", 32'(CFLAG), 32'd0);

    // increment channel 1, BUSY window of two cycles
    CH_SEL = 2'd1;
    DIRECTION = 1'b0;
    MOVE = 1'b1;
    tick();
    chk("inc_busy_step", 32'(BUSY), 32'd0);
    MOVE = 1'b0;
    tick();
    chk("inc_busy_s1", 32'(BUSY), 32'd1);
    tick();
    chk("inc_busy_s2", 32'(BUSY), 32'd1);
    tick();
    chk("inc_busy_end", 32'(BUSY), 32'd0);
    delay_probe(1, 4);
    delay_probe(3, 3);

    // walk channel 2 down to 0, then clamp
    repeat (3) do_move(2, 1'b1);
    chk("clamp_pre", 32'(CFLAG), 32'd0);
    do_move(2, 1'b1);
    chk("clamp_flag", 32'(CFLAG), 32'd1);
    delay_probe(2, 0);
    A = 4'b0000;
    #1;
    chk("clamp_comb0", 32'(Z[2]), 32'd0);
    chk("clamp_sticky", 32'(CFLAG), 32'd1);

    // second edge during SETTLE is dropped
    CH_SEL = 2'd0;
    DIRECTION = 1'b0;
    MOVE = 1'b1;
    tick();
    MOVE = 1'b0;
    tick();
    MOVE = 1'b1;
    tick();
    MOVE = 1'b0;
    repeat (4) tick();
    delay_probe(0, 4);

    // raise ch0 to 7, then LOADN beats a MOVE edge
    repeat (3) do_move(0, 1'b0);
    delay_probe(0, 7);
    CH_SEL = 2'd0;
    MOVE = 1'b1;
    LOADN = 1'b0;
    tick();
    LOADN = 1'b1;
    MOVE = 1'b0;
    chk("load_cflag", 32'(CFLAG), 32'd0);
    chk("load_busy0", 32'(BUSY), 32'd0);
    tick();
    chk("load_busy1", 32'(BUSY), 32'd0);
    tick();
    chk("load_busy2", 32'(BUSY), 32'd0);
    delay_probe(0, 3);
    delay_probe(2, 3);

    // async reset in the middle of SETTLE
    A = 4'hf;
    repeat (6) tick();
    CH_SEL = 2'd1;
    MOVE = 1'b1;
    tick();
    MOVE = 1'b0;
    tick();
    chk("arst_pre_busy", 32'(BUSY), 32'd1);
    #2;
    RST = 1'b1;
    model_reset();
    #1;
    chk("arst_busy", 32'(BUSY), 32'd0);
    chk("arst_z", 32'(Z), 32'd0);
    tick();
    @(negedge clk);
    RST = 1'b0;
    delay_probe(1, 3);

    // random traffic against the model
    for (int n = 0; n < 600; n++) begin
      A         = NCH'($urandom);
      MOVE      = ($urandom_range(0, 2) == 0);
      DIRECTION = 1'($urandom);
      CH_SEL    = 2'($urandom_range(0, 3));
      LOADN     = ($urandom_range(0, 24) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/delay_tap_ctrl.md
Name: delay_tap_ctrl

Overview:
Parametrised, multi-channel successor to the fixed input-delay primitive. Each channel delays its input by a programmable number of CLK-cycle taps. Taps can be loaded from a default, or stepped up/down at run time by a MOVE/DIRECTION controller with settle time and clamp flag. Used in the simulation library as the behavioural model for dynamic input-delay cells on the XO2-class flow.

Parameters:
NCH, 4, number of independent delay channels (1..16)
TAPS, 32, taps per channel; legal tap index 0..TAPS-1 (power of two not required, >=2)
DEL_MODE, "USER_DEFINED", "USER_DEFINED" uses DEL_VALUE as default tap; "SCLK_ZEROHOLD" forces default tap 0
DEL_VALUE, 0, default tap index after reset/load; clamped to TAPS-1
SETTLE_CYC, 2, cycles BUSY stays high after each tap change (>=1)

Ports:
CLK  input  1  sampling/control clock
RST  input  1  asynchronous reset, active-high
A  input  NCH  channel data inputs
Z  output  NCH  delayed channel outputs
LOADN  input  1  synchronous active-low load of default tap into all channels
MOVE  input  1  step request; acted on at rising edge (sampled 0 then 1)
DIRECTION  input  1  0 = increment tap, 1 = decrement tap
CH_SEL  input  $clog2(NCH) (min 1)  channel addressed by MOVE
BUSY  output  1  high during SETTLE; MOVE edges ignored
CFLAG  output  1  sticky clamp flag: step attempted beyond 0 or TAPS-1

Behaviour:
- Clock and reset: one clock, CLK. RST is asynchronous, active-high.
- Reset values: all tap counters = default tap; delay-line history = 0; Z = 0; BUSY = 0; CFLAG = 0; move-edge register = 0; FSM = IDLE.
- Delay line: per channel, a shift register of depth TAPS-1, clocked every CLK.
- Z[i] = A[i] combinationally when tap[i] = 0.
- Otherwise Z[i] = A[i] sampled tap[i] cycles earlier: tap 1 gives a 1-cycle registered delay.
- Move edge: move_q <= MOVE each cycle. Edge = MOVE & ~move_q.
- FSM states:
  - IDLE: on edge, go to STEP.
  - STEP (1 cycle): apply the step to tap[CH_SEL] captured at the edge, then go to SETTLE.
  - SETTLE: counter runs SETTLE_CYC cycles with BUSY = 1, then returns to IDLE.
- Step rules:
  - DIRECTION = 0 and tap = TAPS-1: tap unchanged, CFLAG <= 1.
  - DIRECTION = 1 and tap = 0: tap unchanged, CFLAG <= 1.
  - A clamped step still passes through SETTLE.
- BUSY timing: BUSY is high from the cycle after STEP through the end of SETTLE. Edges arriving while in STEP or SETTLE are dropped (not queued).
- LOADN = 0 at a CLK edge:
  - All taps get the default and CFLAG clears.
  - FSM returns to IDLE and BUSY = 0.
  - LOADN has priority over a simultaneous MOVE edge.
  - Delay-line history is retained.
- Tap change: takes effect on Z the cycle after STEP. Z then selects the new history element; no history flush.
- CH_SEL >= NCH: step ignored, FSM still runs STEP/SETTLE.
- RST mid-SETTLE: immediate return to reset values.
- DEL_VALUE >= TAPS: default = TAPS-1.

Optional Feature:
DELAY_TAPOUT_EN:
- Defined: adds output TAP_OUT, width NCH*$clog2(TAPS), exposing all tap counters (channel 0 in LSBs). Resets to the default-tap pattern and updates the cycle after STEP or LOADN.
- Undefined: port absent; behaviour otherwise identical.

Decomposition:
- Package delay_tap_pkg:
  - FSM state enum (IDLE, STEP, SETTLE).
  - Function clamp_default(DEL_MODE, DEL_VALUE, TAPS).
  - Constant TAP_W = $clog2(TAPS).
- Sub-module delay_tap_line: one channel's shift register and tap mux, parameters TAPS. Instantiated NCH times by generate.

Test Plan:
- Reset, defaults NCH=4 TAPS=32 DEL_VALUE=3: RST pulse, drive A[0] 0→1 → Z[0] rises exactly 3 CLK edges later; BUSY=0, CFLAG=0 throughout.
- Increment: CH_SEL=1, DIRECTION=0, MOVE pulse → BUSY high 2 cycles; Z[1] delay becomes 4 cycles; other channels stay at 3.
- Clamp low: DEL_VALUE=0, DIRECTION=1, MOVE pulse on ch2 → tap stays 0, CFLAG=1 sticky; Z[2] remains combinational copy of A[2].
- Busy drop: two MOVE rising edges 1 cycle apart (second during SETTLE) on ch0, DIRECTION=0 → tap 3→4 only.
- Load priority: LOADN=0 coincident with MOVE edge while tap[0]=7 → tap[0]=3, CFLAG=0, BUSY=0, no step.
- Async reset mid-SETTLE: assert RST between clock edges → BUSY=0, Z=0 immediately, taps = 3 after release.
